// File: rtl/key_debounce_multi_if.sv
// Key pins in, debounced levels and event strobes out, all in the clk domain.
// Strobes are single-cycle pulses and carry no handshake. The consumer samples them every cycle.
interface key_debounce_multi_if #(
  parameter int KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;
  logic [KEY_NUM-1:0] dbg_armed;

  modport master (
    output key_in,
    input  key_state, key_press, key_release, key_long, dbg_armed
  );

  modport slave (
    input  key_in,
    output key_state, key_press, key_release, key_long, dbg_armed
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-flop sync, edge-restarted settle timer, press/release/long strobes.
// Each channel is fully independent; dbg_armed exposes the settle FSM state per channel.
module key_debounce_multi #(
  parameter int KEY_NUM    = 4,
  parameter int TIME_20MS  = 1_000_000,
  parameter int LONG_TIME  = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  key_debounce_multi_if.slave bus
);
  localparam int CNT_W  = $clog2(TIME_20MS);
  localparam int LCNT_W = $clog2(LONG_TIME + 1);
  localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIME_20MS - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_TIME - 1);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic              r0, r1;
    logic              armed, armed_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              edge_det, level, commit;
    logic              state_q, state_nxt;
    logic              press_q, release_q, long_q;
    logic [LCNT_W-1:0] lcnt, lcnt_nxt;
    logic              long_done, long_done_nxt, long_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r0        <= IDLE_LVL;
        r1        <= IDLE_LVL;
        armed     <= 1'b0;
        cnt       <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        lcnt      <= '0;
        long_done <= 1'b0;
      end else begin
        r0        <= bus.key_in[i];
        r1        <= r0;
        armed     <= armed_nxt;
        cnt       <= cnt_nxt;
        state_q   <= state_nxt;
        press_q   <= commit & state_nxt & ~state_q;
        release_q <= commit & ~state_nxt & state_q;
        long_q    <= long_hit;
        lcnt      <= lcnt_nxt;
        long_done <= long_done_nxt;
      end
    end

    // Next-state logic; a fresh edge outranks a terminal count
    always_comb begin
      edge_det  = r0 ^ r1;
      level     = ACTIVE_LOW ? ~r1 : r1;
      commit    = 1'b0;
      armed_nxt = armed;
      cnt_nxt   = cnt;
      state_nxt = state_q;
      if (edge_det) begin
        armed_nxt = 1'b1;
        cnt_nxt   = '0;
      end else if (armed && cnt == CNT_LAST) begin
        armed_nxt = 1'b0;
        cnt_nxt   = '0;
        commit    = 1'b1;
        state_nxt = level;
      end else if (armed) begin
        cnt_nxt = cnt + 1'b1;
      end

      long_hit      = 1'b0;
      lcnt_nxt      = lcnt;
      long_done_nxt = long_done;
      if (!state_q) begin
        lcnt_nxt      = '0;
        long_done_nxt = 1'b0;
      end else if (!long_done) begin
        if (lcnt == LCNT_LAST) begin
          long_hit      = 1'b1;
          long_done_nxt = 1'b1;
        end else begin
          lcnt_nxt = lcnt + 1'b1;
        end
      end
    end

    // Outputs
    assign bus.key_state[i]   = state_q;
    assign bus.key_press[i]   = press_q;
    assign bus.key_release[i] = release_q;
    assign bus.key_long[i]    = long_q;
    assign bus.dbg_armed[i]   = armed;
  end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed and randomized bench for key_debounce_multi against a sample-history reference model.
module tb_key_debounce_multi;
  localparam int KEY_NUM    = 4;
  localparam int TIME_20MS  = 8;
  localparam int LONG_TIME  = 32;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int W = 4 * KEY_NUM;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.KEY_NUM(KEY_NUM)) bus ();

  key_debounce_multi #(
    .KEY_NUM(KEY_NUM), .TIME_20MS(TIME_20MS), .LONG_TIME(LONG_TIME), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: run = consecutive equal samples seen so far on each pin
  bit m_last  [KEY_NUM];
  int m_run   [KEY_NUM];
  bit m_pend  [KEY_NUM];
  bit m_state [KEY_NUM];
  int m_age   [KEY_NUM];
  bit m_fired [KEY_NUM];

  int n_press[KEY_NUM], n_rel[KEY_NUM], n_long[KEY_NUM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [KEY_NUM-1:0] e_st, e_pr, e_rl, e_lg;
    bit v, nst;
    e_pr = '0; e_rl = '0; e_lg = '0; e_st = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (!rst_n) begin
        m_last[i] = ACTIVE_LOW; m_run[i] = TIME_20MS + 2; m_pend[i] = 0;
        m_state[i] = 0; m_age[i] = 0; m_fired[i] = 0;
      end else begin
        v = bus.key_in[i];
        if (m_state[i]) begin
          if (m_age[i] < LONG_TIME) m_age[i]++;
          if (m_age[i] == LONG_TIME && !m_fired[i]) begin
            e_lg[i] = 1'b1;
            m_fired[i] = 1;
          end
        end else begin
          m_age[i] = 0;
          m_fired[i] = 0;
        end
        // A level must be seen on TIME_20MS+1 consecutive edges before it is committed
        if (m_pend[i] && m_run[i] == TIME_20MS + 1) begin
          nst = ACTIVE_LOW ? !m_last[i] : m_last[i];
          if (nst && !m_state[i]) e_pr[i] = 1'b1;
          if (!nst && m_state[i]) e_rl[i] = 1'b1;
          m_state[i] = nst;
          m_pend[i] = 0;
        end
        if (v != m_last[i]) begin
          m_last[i] = v; m_run[i] = 1; m_pend[i] = 1;
        end else if (m_run[i] < TIME_20MS + 2) begin
          m_run[i]++;
        end
      end
      e_st[i] = m_state[i];
    end
    exp_q.push_back({e_st, e_pr, e_rl, e_lg});
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("key_state",   32'(bus.key_state),   32'(e[4*KEY_NUM-1:3*KEY_NUM]));
    chk("key_press",   32'(bus.key_press),   32'(e[3*KEY_NUM-1:2*KEY_NUM]));
    chk("key_release", 32'(bus.key_release), 32'(e[2*KEY_NUM-1:KEY_NUM]));
    chk("key_long",    32'(bus.key_long),    32'(e[KEY_NUM-1:0]));
    for (int i = 0; i < KEY_NUM; i++) begin
      n_press[i] += int'(bus.key_press[i]);
      n_rel[i]   += int'(bus.key_release[i]);
      n_long[i]  += int'(bus.key_long[i]);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < KEY_NUM; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
    end
  endtask

  int hold[KEY_NUM];

  initial begin
    bus.key_in = 4'hF;
    clear_counts();

    // 1. Reset with toggling pins, then quiet idle
    for (int k = 0; k < 6; k++) begin
      bus.key_in = 4'($urandom_range(0, 15));
      step();
    end
    bus.key_in = 4'hF;
    rst_n = 1'b1;
    clear_counts();
    step(50);
    chk("t1_idle_press", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3]), 32'd0);

    // 2. Clean press on channel 0 commits on edge 10
    clear_counts();
    bus.key_in[0] = 1'b0;
    step(9);
    chk("t2_before", 32'(bus.key_state), 32'h0);
    step();
    chk("t2_state", 32'(bus.key_state), 32'h1);
    chk("t2_press", 32'(bus.key_press), 32'h1);
    step(5);
    chk("t2_nrel", 32'(n_rel[0]), 32'd0);

    // 3. Bouncing press on channel 1, then a glitch that returns
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      if (c % 3 == 0) bus.key_in[1] = ~bus.key_in[1];
      step();
    end
    bus.key_in[1] = 1'b0;
    step(12);
    chk("t3_npress", 32'(n_press[1]), 32'd1);
    chk("t3_state", 32'(bus.key_state[1]), 32'd1);
    bus.key_in[1] = 1'b1;
    step(12);
    clear_counts();
    bus.key_in[1] = 1'b0;
    step(5);
    bus.key_in[1] = 1'b1;
    step(15);
    chk("t3_glitch_press", 32'(n_press[1] + n_rel[1]), 32'd0);
    chk("t3_glitch_state", 32'(bus.key_state[1]), 32'd0);

    // 4. Long press on channel 2, release, short press
    clear_counts();
    bus.key_in[2] = 1'b0;
    step(60);
    chk("t4_npress", 32'(n_press[2]), 32'd1);
    chk("t4_nlong", 32'(n_long[2]), 32'd1);
    bus.key_in[2] = 1'b1;
    step(12);
    chk("t4_nrel", 32'(n_rel[2]), 32'd1);
    clear_counts();
    bus.key_in[2] = 1'b0;
    step(20);
    bus.key_in[2] = 1'b1;
    step(12);
    chk("t4_short_long", 32'(n_long[2]), 32'd0);

    // 5. All keys together, then an edge colliding with the terminal count
    bus.key_in = 4'hF;
    step(15);
    bus.key_in = 4'h0;
    step(10);
    chk("t5_all_press", 32'(bus.key_press), 32'hF);
    bus.key_in = 4'hF;
    step(15);
    bus.key_in[3] = 1'b0;
    step(8);
    bus.key_in[3] = 1'b1;
    step();
    bus.key_in[3] = 1'b0;
    step();
    chk("t5_no_commit", 32'(bus.key_state[3]), 32'd0);
    step(8);
    chk("t5_pre_commit", 32'(bus.key_state[3]), 32'd0);
    step();
    chk("t5_late_press", 32'(bus.key_press), 32'h8);
    bus.key_in = 4'hF;
    step(15);

    // 6. Asynchronous reset in the middle of a pending press
    bus.key_in[0] = 1'b0;
    step(7);
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(bus.key_state), 32'h0);
    chk("t6_async_press", 32'(bus.key_press), 32'h0);
    step(3);
    rst_n = 1'b1;
    step(9);
    chk("t6_before", 32'(bus.key_state[0]), 32'd0);
    step();
    chk("t6_press", 32'(bus.key_press), 32'h1);
    bus.key_in = 4'hF;
    step(15);

    // Randomized bounces, short and long holds on every channel
    for (int i = 0; i < KEY_NUM; i++) hold[i] = $urandom_range(1, 12);
    for (int k = 0; k < 900; k++) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          bus.key_in[i] = ~bus.key_in[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 55) : $urandom_range(1, 12);
        end
      end
      step();
    end
    bus.key_in = 4'hF;
    step(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
